stage2_final: RTL and testbench
===============================

STAGE2_FINAL -- requirements
Module: stage2_final

Interface
REQ-001 Parameter COMP_EN, default 1, meaning: 1 adds the error-compensation term from V1/V2, 0 ignores V1/V2.
REQ-002 Parameter CNT_W, default 16, meaning: width of the completed-result counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  P7/Q7/V1/V2 valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 P7  input  15  first compressed partial-product row from the compression stage.
REQ-008 Q7  input  15  second compressed partial-product row.
REQ-009 V1  input  13  error vector of the 8-row compression level.
REQ-010 V2  input  11  error vector of the 4-row compression level.
REQ-011 out_valid  output  1  product valid.
REQ-012 out_ready  input  1  downstream accepts product.
REQ-013 product  output  16  final 16-bit product.
REQ-014 ovf  output  1  carry out of bit 15 of the final sum for this product.
REQ-015 out_count  output  CNT_W  number of output handshakes completed.

Function
REQ-016 Input handshake occurs when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-017 Two-stage pipeline, S1 then S2, each holding a valid bit plus data.
REQ-018 S1 captures P7, Q7 and COMP = ({V1,1'b0} + {V2,3'b000}) zero-extended to 17 bits, or COMP = 0 when COMP_EN=0.
REQ-019 S2 computes the 17-bit sum P7 + Q7 + COMP (all zero-extended); product = sum[15:0], ovf = sum[16].
REQ-020 Latency: an input accepted in cycle N produces out_valid in cycle N+2 when no stall occurs.
REQ-021 Throughput is one result per cycle while out_ready=1.
REQ-022 S2 loads from S1 when S2 is empty or the output handshake occurs this cycle; otherwise S2 holds.
REQ-023 in_ready = !S1.valid || S2 loads this cycle; it is combinational from out_ready and the valid bits only.
REQ-024 Under backpressure the block holds at most 2 entries; it neither drops, duplicates nor reorders results.
REQ-025 product and ovf remain stable while out_valid=1 and out_ready=0.
REQ-026 out_count increments by 1 on each output handshake and wraps from all-ones to 0.
REQ-027 Simultaneous input and output handshakes in the same cycle with both stages full shall advance the pipeline with no bubble.

Reset
REQ-028 When rst_n=0 at a clock edge: S1.valid=0, S2.valid=0, out_valid=0, product=0, ovf=0, out_count=0.
REQ-029 in_ready=1 in the first cycle after reset release.
REQ-030 Reset asserted mid-operation discards all in-flight entries; no result from before reset appears afterwards.

Structure
REQ-031 A shared package stage_pkg holds the width constants P_W=15, V1_W=13, V2_W=11 and PROD_W=16, and the 17-bit comp/sum typedefs.
REQ-032 One sub-module, stage2_cadd, holds the combinational 17-bit three-operand adder used in S2; all control stays in stage2_final.

Verification
REQ-033 COMP_EN=1, P7=0x00FF, Q7=0x0001, V1=0, V2=0, out_ready=1 -> product=0x0100, ovf=0, out_valid exactly 2 cycles after accept.
REQ-034 COMP_EN=1, P7=0, Q7=0, V1=1, V2=1 -> product=0x000A; the same input with COMP_EN=0 -> product=0x0000.
REQ-035 COMP_EN=1, P7=0x7FFF, Q7=0x7FFF, V1=0x1FFF, V2=0x7FF -> product=0x7FF4, ovf=1.
REQ-036 Stream 5 inputs (P7=1..5, rest 0) with out_ready=0 for 4 cycles, then 1 -> in_ready falls after 2 accepts; outputs 1..5 appear in order; out_count ends at 5.
REQ-037 Preload out_count=all-ones, then 1 handshake -> out_count=0; rst_n=0 for 1 cycle with both stages full -> out_valid=0 next cycle and no stale product afterwards.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared constants and types for the final product stage.
// P_W    : width of the compressed partial-product rows P7/Q7
// V1_W   : width of the 8-row level error vector
// V2_W   : width of the 4-row level error vector
// PROD_W : width of the final product
// comp_t/sum_t : 17-bit compensation and sum words (product plus carry)
package stage_pkg;

    localparam int unsigned P_W    = 15;
    localparam int unsigned V1_W   = 13;
    localparam int unsigned V2_W   = 11;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned SUM_W  = PROD_W + 1;

    typedef logic [SUM_W-1:0] comp_t;
    typedef logic [SUM_W-1:0] sum_t;

    // Error compensation: V1 carries weight 2, V2 carries weight 8.
    function automatic comp_t calc_comp(input logic [V1_W-1:0] v1,
                                        input logic [V2_W-1:0] v2);
        comp_t a;
        comp_t b;
        a = comp_t'({v1, 1'b0});
        b = comp_t'({v2, 3'b000});
        return a + b;
    endfunction

endpackage

// File: rtl/stage2_cadd.sv
// Combinational three-operand adder producing the 17-bit final sum.
// Ports:
//   a, b : P_W-bit partial-product rows (zero-extended)
//   c    : 17-bit compensation word
//   sum  : 17-bit result; bit 16 is the carry out of the product
module stage2_cadd
    import stage_pkg::*;
(
    input  logic [P_W-1:0] a,
    input  logic [P_W-1:0] b,
    input  comp_t          c,
    output sum_t           sum
);

    assign sum = sum_t'(a) + sum_t'(b) + c;

endmodule

// File: rtl/stage2_final.sv
// Final product stage: a two-entry valid/ready pipeline that captures the
// compressed rows and error compensation (S1), then registers their sum (S2).
// Parameters:
//   COMP_EN : 1 adds the V1/V2 compensation term, 0 ignores V1/V2
//   CNT_W   : width of the completed-result counter
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake for P7/Q7/V1/V2
//   P7, Q7              : compressed partial-product rows
//   V1, V2              : error vectors of the 8-row and 4-row levels
//   out_valid/out_ready : output handshake for product/ovf
//   product, ovf        : 16-bit product and carry out of bit 15
//   out_count           : number of output handshakes (wraps)
module stage2_final
    import stage_pkg::*;
#(
    parameter int unsigned COMP_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P_W-1:0]    P7,
    input  logic [P_W-1:0]    Q7,
    input  logic [V1_W-1:0]   V1,
    input  logic [V2_W-1:0]   V2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              ovf,
    output logic [CNT_W-1:0]  out_count
);

    // S1 state
    logic           s1_valid;
    logic [P_W-1:0] s1_p;
    logic [P_W-1:0] s1_q;
    comp_t          s1_comp;

    // S2 state
    logic              s2_valid;
    logic [PROD_W-1:0] s2_prod;
    logic              s2_ovf;
    logic [CNT_W-1:0]  cnt;

    logic  out_hs;
    logic  s2_load;
    logic  in_hs;
    comp_t comp_in;
    sum_t  sum;

    assign out_hs  = s2_valid && out_ready;
    // S2 takes whatever S1 holds whenever its current content is gone or leaving.
    assign s2_load = !s2_valid || out_hs;
    assign in_ready = !s1_valid || s2_load;
    assign in_hs   = in_valid && in_ready;

    assign comp_in = (COMP_EN != 0) ? calc_comp(V1, V2) : '0;

    stage2_cadd u_cadd (
        .a   (s1_p),
        .b   (s1_q),
        .c   (s1_comp),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_q     <= '0;
            s1_comp  <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_ovf   <= 1'b0;
            cnt      <= '0;
        end else begin
            // When in_ready is high S1 is either empty or handing off to S2,
            // so its valid bit simply follows in_valid.
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_hs) begin
                s1_p    <= P7;
                s1_q    <= Q7;
                s1_comp <= comp_in;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_prod <= sum[PROD_W-1:0];
                    s2_ovf  <= sum[PROD_W];
                end
            end
            if (out_hs) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_valid;
    assign product   = s2_prod;
    assign ovf       = s2_ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_stage2_final.sv
// Self-checking bench for stage2_final. Two instances share all inputs:
// dut_a uses the defaults, dut_b has COMP_EN=0 and a 4-bit counter so the
// counter wrap is reached quickly. A scoreboard queue holds expected results.
module tb_stage2_final;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [14:0] p7 = '0;
    logic [14:0] q7 = '0;
    logic [12:0] v1 = '0;
    logic [10:0] v2 = '0;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] product_a, out_count_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [15:0] product_b;
    logic [3:0]  out_count_b;

    always #5 clk = ~clk;

    stage2_final #(.COMP_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .P7(p7), .Q7(q7), .V1(v1), .V2(v2), .out_valid(out_valid_a),
        .out_ready(out_ready), .product(product_a), .ovf(ovf_a), .out_count(out_count_a)
    );

    stage2_final #(.COMP_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .P7(p7), .Q7(q7), .V1(v1), .V2(v2), .out_valid(out_valid_b),
        .out_ready(out_ready), .product(product_b), .ovf(ovf_b), .out_count(out_count_b)
    );

    typedef struct packed {
        logic [15:0] pa;
        logic        oa;
        logic [15:0] pb;
        logic        ob;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] cnt_a = '0;
    logic [3:0]  cnt_b = '0;
    logic        mon_en = 1'b0;
    logic        held = 1'b0;
    logic [16:0] held_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [14:0] p, input logic [14:0] q,
                                          input logic [12:0] a, input logic [10:0] b,
                                          input bit en);
        logic [16:0] c;
        c = en ? (17'(a) * 17'd2 + 17'(b) * 17'd8) : 17'd0;
        return 17'(p) + 17'(q) + c;
    endfunction

    // Monitor: inputs change at posedge+1, so the negedge sees what the next
    // rising edge will act on.
    always @(negedge clk) begin
        exp_t        e;
        logic [16:0] sa, sbv;
        if (mon_en) begin
            check("cnt_a", 32'(out_count_a), 32'(cnt_a));
            check("cnt_b", 32'(out_count_b), 32'(cnt_b));
            check("valid_b", 32'(out_valid_b), 32'(out_valid_a));
            check("ready_b", 32'(in_ready_b), 32'(in_ready_a));
            if (held && out_valid_a) check("stable", 32'({ovf_a, product_a}), 32'(held_val));
            if (!rst_n) begin
                sb.delete();
                cnt_a = '0;
                cnt_b = '0;
                held  = 1'b0;
            end else begin
                if (out_valid_a && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexp_out", 32'(product_a), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("prod_a", 32'(product_a), 32'(e.pa));
                        check("ovf_a", 32'(ovf_a), 32'(e.oa));
                        check("prod_b", 32'(product_b), 32'(e.pb));
                        check("ovf_b", 32'(ovf_b), 32'(e.ob));
                    end
                    cnt_a = cnt_a + 16'd1;
                    cnt_b = cnt_b + 4'd1;
                end
                if (in_valid && in_ready_a) begin
                    sa  = model(p7, q7, v1, v2, 1'b1);
                    sbv = model(p7, q7, v1, v2, 1'b0);
                    sb.push_back('{pa: sa[15:0], oa: sa[16], pb: sbv[15:0], ob: sbv[16]});
                end
                held     = out_valid_a && !out_ready;
                held_val = {ovf_a, product_a};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one input and hold it until accepted (bounded).
    task automatic send(input logic [14:0] p, input logic [14:0] q,
                        input logic [12:0] a, input logic [10:0] b);
        logic hs;
        bit   done;
        done = 0;
        in_valid = 1'b1;
        p7 = p; q7 = q; v1 = a; v2 = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            hs = in_ready_a;
            step();
            if (hs) done = 1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Send, then wait for the result and compare against fixed values.
    task automatic send_expect(input string tag, input logic [14:0] p, input logic [14:0] q,
                               input logic [12:0] a, input logic [10:0] b,
                               input logic [15:0] ea, input logic eo, input logic [15:0] eb);
        bit seen;
        seen = 0;
        send(p, q, a, b);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid_a) begin
                seen = 1;
                check({tag, "_a"}, 32'(product_a), 32'(ea));
                check({tag, "_ovf"}, 32'(ovf_a), 32'(eo));
                check({tag, "_b"}, 32'(product_b), 32'(eb));
            end
            step();
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] base;
        int          k;
        logic        hs;

        // Reset
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_prod", 32'(product_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_cnt", 32'(out_count_a), 32'd0);
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 32'(in_ready_a), 32'd1);
        step();

        // Two-cycle latency
        out_ready = 1'b1;
        send(15'h00FF, 15'h0001, 13'h0, 11'h0);
        @(negedge clk);
        check("lat_n1", 32'(out_valid_a), 32'd0);
        step();
        @(negedge clk);
        check("lat_n2", 32'(out_valid_a), 32'd1);
        check("lat_prod", 32'(product_a), 32'h0100);
        step();

        send_expect("comp", 15'h0, 15'h0, 13'h1, 11'h1, 16'h000A, 1'b0, 16'h0000);
        send_expect("max", 15'h7FFF, 15'h7FFF, 13'h1FFF, 11'h7FF, 16'h7FF4, 1'b1, 16'hFFFE);

        // Backpressure stream: out_ready low for 4 cycles
        repeat (3) step();
        base = cnt_a;
        k = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
            out_ready = (cyc >= 4);
            p7 = 15'(k + 1); q7 = '0; v1 = '0; v2 = '0;
            @(negedge clk);
            if (k == 2 && cyc < 4) check("bp_not_ready", 32'(in_ready_a), 32'd0);
            hs = in_ready_a;
            step();
            if (hs) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("bp_accepts", 32'(k), 32'd5);
        check("bp_count", 32'(out_count_a), 32'(16'(base + 16'd5)));

        // Random traffic; also walks dut_b's counter through several wraps
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            p7 = 15'($urandom); q7 = 15'($urandom);
            v1 = 13'($urandom); v2 = 11'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(15'h0111, 15'h0, 13'h0, 11'h0);
        send(15'h0222, 15'h0, 13'h0, 11'h0);
        @(negedge clk);
        check("full_valid", 32'(out_valid_a), 32'd1);
        check("full_not_ready", 32'(in_ready_a), 32'd0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid_a), 32'd0);
        check("mid_rst_prod", 32'(product_a), 32'd0);
        check("mid_rst_ready", 32'(in_ready_a), 32'd1);
        step();
        out_ready = 1'b1;
        repeat (6) step();
        send_expect("post_rst", 15'h0333, 15'h0001, 13'h0, 11'h0, 16'h0334, 1'b0, 16'h0334);
        repeat (3) step();
        check("final_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
